sound_latch: RTL

Byte mailbox between the main M68K and the Z80 sound CPU. The M68K writes command bytes through its latch chip select; the Z80 reads them through its latch memory select and acknowledges by writing the same address. The block drives the Z80 NMI while a command is pending and returns a status byte on the M68K sound-status read. It sits between the address decoder's select outputs and the two CPU data buses.

---
 rtl/sound_latch_pkg.sv | 15 +
 rtl/sound_latch_fifo.sv | 54 +++++
 rtl/sound_latch.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sound_latch_pkg.sv
// Shared definitions for the M68K -> Z80 sound command mailbox:
// status byte bit positions and the NMI request state encoding.
package sound_pkg;

  localparam int unsigned STAT_PEND = 0;
  localparam int unsigned STAT_FULL = 1;
  localparam int unsigned STAT_OVF  = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } nmi_state_e;

endpackage

// File: rtl/sound_latch_fifo.sv
// sync_fifo_8: DEPTH-entry byte FIFO with simultaneous push/pop, used by
// sound_latch when SOUND_LATCH_FIFO_EN is defined.
module sync_fifo_8 #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               din_i,
  output logic [7:0]               dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          empty, pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign pop_ok  = pop_i & ~empty;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign drop_o  = push_i & ~push_ok;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sound_latch.sv
// M68K -> Z80 sound command mailbox with NMI pacing and status byte.
// Define SOUND_LATCH_FIFO_EN for a DEPTH-entry FIFO instead of a single latch.
module sound_latch
  import sound_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NMI_GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m68k_latch_cs,
  input  logic       m68k_sound_cs,
  input  logic [7:0] m68k_din,
  output logic [7:0] m68k_status,
  input  logic       z80_latch_cs,
  input  logic       z80_rd_n,
  input  logic       z80_wr_n,
  output logic [7:0] z80_dout,
  output logic       z80_nmi_n
);

  logic       latch_cs_q, snd_cs_q, ack_sel_q;
  logic       wr_ev, ack_ev, rd_ev, ack_sel;
  logic       pend, full, ovf_set;
  logic       ovf_q, nmi_n_q;
  logic [3:0] gap_cnt_q;
  nmi_state_e state_q;
  logic       unused_rd_n;

  // The Z80 read strobe only gates the external data mux.
  assign unused_rd_n = z80_rd_n;

  assign ack_sel = z80_latch_cs & ~z80_wr_n;
  assign wr_ev   = m68k_latch_cs & ~latch_cs_q;
  assign ack_ev  = ack_sel & ~ack_sel_q;
  assign rd_ev   = m68k_sound_cs & ~snd_cs_q;

`ifdef SOUND_LATCH_FIFO_EN
  logic [$clog2(DEPTH):0] count;

  sync_fifo_8 #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (wr_ev),
    .pop_i   (ack_ev),
    .din_i   (m68k_din),
    .dout_o  (z80_dout),
    .count_o (count),
    .full_o  (full),
    .drop_o  (ovf_set)
  );

  assign pend = (count != '0);
`else
  logic [7:0] data_q;
  logic       pend_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      pend_q <= 1'b0;
    end else if (wr_ev) begin
      data_q <= m68k_din;
      pend_q <= 1'b1;
    end else if (ack_ev) begin
      pend_q <= 1'b0;
    end
  end

  assign pend     = pend_q;
  assign full     = 1'b0;
  assign ovf_set  = wr_ev & pend_q & ~ack_ev;
  assign z80_dout = data_q;
`endif

  always_comb begin
    m68k_status           = '0;
    m68k_status[STAT_PEND] = pend;
    m68k_status[STAT_FULL] = full;
    m68k_status[STAT_OVF]  = ovf_q;
  end

  assign z80_nmi_n = nmi_n_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      latch_cs_q <= 1'b0;
      snd_cs_q   <= 1'b0;
      ack_sel_q  <= 1'b0;
      ovf_q      <= 1'b0;
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      nmi_n_q    <= 1'b1;
    end else begin
      latch_cs_q <= m68k_latch_cs;
      snd_cs_q   <= m68k_sound_cs;
      ack_sel_q  <= ack_sel;
      if (ovf_set)    ovf_q <= 1'b1;
      else if (rd_ev) ovf_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (pend) begin
            state_q <= ASSERT;
            nmi_n_q <= 1'b0;
          end
        end
        ASSERT: begin
          if (ack_ev) begin
            state_q   <= GAP;
            gap_cnt_q <= 4'(NMI_GAP);
            nmi_n_q   <= 1'b1;
          end
        end
        GAP: begin
          // Leaving on the decrement that reaches 0 keeps NMI high exactly NMI_GAP cycles.
          if (gap_cnt_q <= 4'd1) begin
            gap_cnt_q <= '0;
            if (pend) begin
              state_q <= ASSERT;
              nmi_n_q <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          nmi_n_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
